// File: rtl/trng_pkg.sv
// Shared types for the TRNG post-processing block.
// Provides the extraction-mode encoding and a small mode classifier.
package trng_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_RAW  = 2'd0,
    MODE_VN   = 2'd1,
    MODE_XOR2 = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  // True for modes that consume samples in non-overlapping pairs.
  function automatic logic is_pair_mode(mode_e m);
    return (m == MODE_VN) || (m == MODE_XOR2);
  endfunction

endpackage

// File: rtl/trng_postproc_if.sv
// Output word handshake between trng_postproc and its consumer.
//   word_out   : assembled random word
//   word_valid : word_out holds an unconsumed word
//   out_ready  : consumer accepts the word this cycle
interface trng_postproc_if #(
  parameter int unsigned BITWIDTH = 8
);
  logic [BITWIDTH-1:0] word_out;
  logic                word_valid;
  logic                out_ready;

  modport master (output word_out, output word_valid, input out_ready);
  modport slave  (input word_out, input word_valid, output out_ready);
endinterface

// File: rtl/trng_bit_extractor.sv
// Sample divider, pair tracking and debias logic for the TRNG raw bit.
//   clk, rst_n       : clock, async active-low reset
//   ena              : low halts sampling and clears the pair phase
//   raw_bit          : synchronised TRNG bit
//   mode             : extraction mode
//   sample_div       : sample every sample_div+1 clocks
//   bit_valid_c      : an extracted bit is available this cycle
//   bit_data_c       : value of the extracted bit
//   flush_c          : downstream partial word must be discarded this cycle
module trng_bit_extractor
  import trng_pkg::*;
#(
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             raw_bit,
  input  mode_e            mode,
  input  logic [DIV_W-1:0] sample_div,
  output logic             bit_valid_c,
  output logic             bit_data_c,
  output logic             flush_c
);

  logic [DIV_W-1:0] r_div;
  logic             r_phase;
  logic             r_a;
  mode_e            r_mode;

  logic w_strobe;
  logic w_mode_chg;
  logic w_take;

  assign w_strobe   = ena && (r_div == sample_div);
  assign w_mode_chg = (mode != r_mode);
  // A sample landing on a mode-change cycle is dropped.
  assign w_take     = w_strobe && !w_mode_chg;
  assign flush_c    = !ena || w_mode_chg;

  // Per-mode bit extraction from the current sample and the stored first half.
  always_comb begin
    bit_valid_c = 1'b0;
    bit_data_c  = 1'b0;
    if (w_take) begin
      case (mode)
        MODE_VN: begin
          if (r_phase) begin
            bit_valid_c = (r_a != raw_bit);
            bit_data_c  = r_a;
          end
        end
        MODE_XOR2: begin
          if (r_phase) begin
            bit_valid_c = 1'b1;
            bit_data_c  = r_a ^ raw_bit;
          end
        end
        default: begin
          bit_valid_c = 1'b1;
          bit_data_c  = raw_bit;
        end
      endcase
    end
  end

  // Divider, mode copy and pair-phase state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_phase <= 1'b0;
      r_a     <= 1'b0;
      r_mode  <= MODE_RAW;
    end else begin
      r_mode <= mode;

      if (!ena || w_strobe) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + DIV_W'(1);
      end

      if (flush_c) begin
        r_phase <= 1'b0;
      end else if (w_take && is_pair_mode(mode)) begin
        r_phase <= !r_phase;
        r_a     <= raw_bit;
      end
    end
  end

endmodule

// File: rtl/trng_postproc.sv
// TRNG post-processing top: bit extraction, word assembly, output
// register with valid/ready handshake, and saturating bit statistics.
//   clk, rst_n  : clock, async active-low reset
//   ena         : design enable
//   raw_bit     : synchronised TRNG bit
//   mode        : 0 RAW, 1 von Neumann, 2 XOR-pair, 3 treated as RAW
//   sample_div  : sample every sample_div+1 clocks
//   stat_clr    : clears statistics and overflow
//   bus         : word_out / word_valid / out_ready handshake
//   overflow    : sticky, a completed word was dropped
//   bit_count   : extracted bits, saturating
//   ones_count  : extracted 1 bits, saturating
module trng_postproc
  import trng_pkg::*;
#(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned DIV_W    = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              raw_bit,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  sample_div,
  input  logic              stat_clr,
  trng_postproc_if.master   bus,
  output logic              overflow,
  output logic [CNT_W-1:0]  bit_count,
  output logic [CNT_W-1:0]  ones_count
);

  localparam int unsigned FILL_W = $clog2(BITWIDTH + 1);

  logic [BITWIDTH-1:0] r_shreg;
  logic [FILL_W-1:0]   r_fill;
  logic [BITWIDTH-1:0] r_word;
  logic                r_valid;
  logic                r_ovf;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [CNT_W-1:0]    r_ones_cnt;

  mode_e               w_mode;
  logic                w_bit_valid;
  logic                w_bit_data;
  logic                w_flush;
  logic                w_xfer;
  logic                w_word_done;
  logic                w_load;
  logic                w_drop;
  logic [BITWIDTH-1:0] w_shreg_nxt;

  assign w_mode = mode_e'(mode);

  trng_bit_extractor #(
    .DIV_W (DIV_W)
  ) u_extractor (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .raw_bit     (raw_bit),
    .mode        (w_mode),
    .sample_div  (sample_div),
    .bit_valid_c (w_bit_valid),
    .bit_data_c  (w_bit_data),
    .flush_c     (w_flush)
  );

  // First extracted bit ends up in the MSB.
  assign w_shreg_nxt = {r_shreg[BITWIDTH-2:0], w_bit_data};
  assign w_xfer      = r_valid && bus.out_ready;
  assign w_word_done = w_bit_valid && (r_fill == FILL_W'(BITWIDTH - 1));
  // A finished word may replace one that is leaving on the same edge.
  assign w_load      = w_word_done && (!r_valid || w_xfer);
  assign w_drop      = w_word_done && !w_load;

  // Word assembly and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= '0;
      r_fill  <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_flush) begin
        r_shreg <= '0;
        r_fill  <= '0;
      end else if (w_word_done) begin
        r_shreg <= '0;
        r_fill  <= '0;
      end else if (w_bit_valid) begin
        r_shreg <= w_shreg_nxt;
        r_fill  <= r_fill + FILL_W'(1);
      end

      if (w_load) begin
        r_word  <= w_shreg_nxt;
        r_valid <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Saturating statistics and sticky overflow; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf      <= 1'b0;
      r_bit_cnt  <= '0;
      r_ones_cnt <= '0;
    end else if (stat_clr) begin
      r_ovf      <= 1'b0;
      r_bit_cnt  <= '0;
      r_ones_cnt <= '0;
    end else begin
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
      if (w_bit_valid && (r_bit_cnt != {CNT_W{1'b1}})) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
      if (w_bit_valid && w_bit_data && (r_ones_cnt != {CNT_W{1'b1}})) begin
        r_ones_cnt <= r_ones_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.word_out   = r_word;
  assign bus.word_valid = r_valid;
  assign overflow       = r_ovf;
  assign bit_count      = r_bit_cnt;
  assign ones_count     = r_ones_cnt;

endmodule

// File: tb/tb_trng_postproc.sv
// Self-checking bench for trng_postproc: table-driven directed vectors,
// hand-written reset/backpressure/saturation/mode-change sequences, and
// random stimulus compared every cycle against a queue-based model.
module tb_trng_postproc;

  localparam int unsigned BW = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       raw_bit;
  logic [1:0] mode;
  logic [3:0] sample_div;
  logic       stat_clr;
  logic       out_ready;

  logic        overflow, overflow_s;
  logic [15:0] bit_count, ones_count;
  logic [3:0]  bit_count_s, ones_count_s;

  trng_postproc_if #(.BITWIDTH(BW)) bus ();
  trng_postproc_if #(.BITWIDTH(BW)) bus_s ();
  assign bus.out_ready   = out_ready;
  assign bus_s.out_ready = out_ready;

  trng_postproc #(.BITWIDTH(BW), .DIV_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .raw_bit(raw_bit), .mode(mode),
    .sample_div(sample_div), .stat_clr(stat_clr), .bus(bus),
    .overflow(overflow), .bit_count(bit_count), .ones_count(ones_count)
  );

  // Small-counter instance used only for saturation checks.
  trng_postproc #(.BITWIDTH(BW), .DIV_W(4), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .ena(ena), .raw_bit(raw_bit), .mode(mode),
    .sample_div(sample_div), .stat_clr(stat_clr), .bus(bus_s),
    .overflow(overflow_s), .bit_count(bit_count_s), .ones_count(ones_count_s)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  int       m_div;
  bit       m_pend[$];
  bit       m_bits[$];
  bit [7:0] m_out;
  bit       m_valid;
  bit       m_ovf;
  int       m_bc, m_oc;
  bit [1:0] m_mode_prev;

  task automatic model_reset();
    m_div = 0; m_pend.delete(); m_bits.delete();
    m_out = 0; m_valid = 0; m_ovf = 0; m_bc = 0; m_oc = 0; m_mode_prev = 0;
  endtask

  task automatic model_step();
    bit xfer, chg, smp, emit, b, loaded, a;
    bit [7:0] w;
    xfer = m_valid && out_ready;
    chg = (mode != m_mode_prev);
    m_mode_prev = mode;
    emit = 0; b = 0; loaded = 0;
    if (!ena) begin
      m_div = 0; m_pend.delete(); m_bits.delete();
    end else begin
      smp = (m_div == int'(sample_div));
      m_div = smp ? 0 : (m_div + 1) % 16;
      if (chg) begin
        m_pend.delete(); m_bits.delete();
      end else if (smp) begin
        if (mode == 2'd1 || mode == 2'd2) begin
          m_pend.push_back(raw_bit);
          if (m_pend.size() == 2) begin
            a = m_pend[0];
            if (mode == 2'd2) begin emit = 1; b = a ^ m_pend[1]; end
            else if (a != m_pend[1]) begin emit = 1; b = a; end
            m_pend.delete();
          end
        end else begin
          emit = 1; b = raw_bit;
        end
      end
    end
    if (emit) begin
      if (m_bc < 65535) m_bc++;
      if (b && m_oc < 65535) m_oc++;
      m_bits.push_back(b);
      if (m_bits.size() == BW) begin
        w = 0;
        foreach (m_bits[i]) w = {w[6:0], m_bits[i]};
        m_bits.delete();
        if (!m_valid || xfer) begin m_out = w; loaded = 1; end
        else m_ovf = 1;
      end
    end
    if (stat_clr) begin m_bc = 0; m_oc = 0; m_ovf = 0; end
    if (loaded) m_valid = 1;
    else if (xfer) m_valid = 0;
  endtask

  // ---------------- cycle helper with transfer monitor ----------------
  bit [7:0] got_words[$];
  int       n_valid_cycles;

  task automatic step();
    if (bus.word_valid) n_valid_cycles++;
    if (bus.word_valid && out_ready) got_words.push_back(bus.word_out);
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic clear_mon();
    got_words.delete();
    n_valid_cycles = 0;
  endtask

  // Feed samples MSB-first from a packed pattern, each held for div+1 clocks.
  task automatic feed(input logic [31:0] pat, input int n, input int div);
    for (int s = 0; s < n; s++) begin
      raw_bit = pat[n - 1 - s];
      repeat (div + 1) step();
    end
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  div;
    logic [31:0] samp;
    int          nsamp;
    logic [7:0]  exp_word;
    int          exp_bc;
    int          exp_oc;
  } vec_t;

  vec_t vecs[3];

  initial begin
    vecs[0] = '{mode: 2'd0, div: 4'd0, samp: 32'h000000B2, nsamp: 8,  exp_word: 8'hB2, exp_bc: 8, exp_oc: 4};
    vecs[1] = '{mode: 2'd1, div: 4'd0, samp: 32'h78787878, nsamp: 32, exp_word: 8'h55, exp_bc: 8, exp_oc: 4};
    vecs[2] = '{mode: 2'd2, div: 4'd3, samp: 32'h0000FFFF, nsamp: 16, exp_word: 8'h00, exp_bc: 8, exp_oc: 0};

    rst_n = 0; ena = 0; raw_bit = 0; mode = 0; sample_div = 0; stat_clr = 0; out_ready = 1;
    model_reset();
    repeat (3) step();
    chk("reset_word_out", 32'(bus.word_out), 32'h0);
    chk("reset_word_valid", 32'(bus.word_valid), 32'h0);
    chk("reset_overflow", 32'(overflow), 32'h0);
    chk("reset_bit_count", 32'(bit_count), 32'h0);
    chk("reset_ones_count", 32'(ones_count), 32'h0);
    rst_n = 1;
    step();

    // Table-driven single-word vectors.
    foreach (vecs[i]) begin
      mode = vecs[i].mode; sample_div = vecs[i].div;
      ena = 0; stat_clr = 1; out_ready = 1;
      step();
      stat_clr = 0; ena = 1;
      clear_mon();
      feed(vecs[i].samp, vecs[i].nsamp, int'(vecs[i].div));
      ena = 0;
      repeat (2) step();
      chk($sformatf("vec%0d_num_words", i), 32'(got_words.size()), 32'd1);
      if (got_words.size() > 0) chk($sformatf("vec%0d_word", i), 32'(got_words[0]), 32'(vecs[i].exp_word));
      chk($sformatf("vec%0d_valid_cycles", i), 32'(n_valid_cycles), 32'd1);
      chk($sformatf("vec%0d_bit_count", i), 32'(bit_count), 32'(vecs[i].exp_bc));
      chk($sformatf("vec%0d_ones_count", i), 32'(ones_count), 32'(vecs[i].exp_oc));
    end

    // Reset mid-word, then a word built only from post-reset samples.
    mode = 0; sample_div = 0; out_ready = 1; ena = 0; stat_clr = 1;
    step();
    stat_clr = 0; ena = 1;
    feed(32'h1F, 5, 0);
    chk("pre_reset_bit_count", 32'(bit_count), 32'd5);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    chk("midreset_bit_count", 32'(bit_count), 32'h0);
    chk("midreset_ones_count", 32'(ones_count), 32'h0);
    chk("midreset_valid", 32'(bus.word_valid), 32'h0);
    @(negedge clk);
    step();
    rst_n = 1;
    clear_mon();
    feed(32'hC3, 8, 0);
    ena = 0;
    repeat (2) step();
    chk("postreset_num_words", 32'(got_words.size()), 32'd1);
    if (got_words.size() > 0) chk("postreset_word", 32'(got_words[0]), 32'hC3);

    // Backpressure: first word held, later words dropped.
    ena = 0; stat_clr = 1; out_ready = 0;
    step();
    stat_clr = 0; ena = 1;
    feed(32'hA5, 8, 0);
    chk("bp_first_valid", 32'(bus.word_valid), 32'd1);
    feed(32'h3C, 8, 0);
    chk("bp_word_held1", 32'(bus.word_out), 32'hA5);
    chk("bp_overflow", 32'(overflow), 32'd1);
    feed(32'h0F, 8, 0);
    chk("bp_word_held2", 32'(bus.word_out), 32'hA5);
    chk("bp_bit_count", 32'(bit_count), 32'd24);
    ena = 0; out_ready = 1;
    step();
    out_ready = 0;
    chk("bp_valid_falls", 32'(bus.word_valid), 32'd0);
    stat_clr = 1;
    step();
    stat_clr = 0;
    chk("bp_clr_overflow", 32'(overflow), 32'd0);
    chk("bp_clr_bit_count", 32'(bit_count), 32'd0);
    chk("bp_clr_ones_count", 32'(ones_count), 32'd0);

    // Saturation on the 4-bit counter instance.
    out_ready = 1; mode = 0; ena = 1;
    feed(32'hFFFFF, 20, 0);
    chk("sat_bit_count", 32'(bit_count_s), 32'hF);
    chk("sat_ones_count", 32'(ones_count_s), 32'hF);
    chk("sat_wide_bit_count", 32'(bit_count), 32'd20);
    feed(32'h3, 2, 0);
    chk("sat_bit_count_held", 32'(bit_count_s), 32'hF);

    // Mode change mid-word discards the partial word.
    ena = 0; stat_clr = 1;
    step();
    stat_clr = 0; ena = 1;
    clear_mon();
    feed(32'h7, 3, 0);
    mode = 2'd2; raw_bit = 1; step();
    mode = 2'd0; raw_bit = 1; step();
    feed(32'h81, 8, 0);
    ena = 0;
    repeat (2) step();
    chk("modechg_num_words", 32'(got_words.size()), 32'd1);
    if (got_words.size() > 0) chk("modechg_word", 32'(got_words[0]), 32'h81);
    chk("modechg_bit_count", 32'(bit_count), 32'd11);

    // Random stimulus against the model.
    for (int c = 0; c < 3000; c++) begin
      ena = ($urandom_range(0, 19) != 0);
      raw_bit = ($urandom_range(0, 99) < 65);
      if ($urandom_range(0, 99) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) sample_div = 4'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      stat_clr = ($urandom_range(0, 299) == 0);
      step();
      chk("rand_word_valid", 32'(bus.word_valid), 32'(m_valid));
      chk("rand_word_out", 32'(bus.word_out), 32'(m_out));
      chk("rand_overflow", 32'(overflow), 32'(m_ovf));
      chk("rand_bit_count", 32'(bit_count), 32'(m_bc));
      chk("rand_ones_count", 32'(ones_count), 32'(m_oc));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/trng_postproc.md
Name: trng_postproc

Overview:
Post-processing stage directly downstream of the biased ring-oscillator TRNG and its two-flop synchroniser. Consumes the synchronised raw bit, samples it at a programmable rate, optionally debiases it (von Neumann or XOR-pair), packs bits into words and presents them on a valid/ready interface. Keeps running bit/ones statistics so bias-control settings can be characterised from outside the chip.

Parameters:
BITWIDTH, 8, output word width in bits
DIV_W, 4, width of the sample-divider setting
CNT_W, 16, width of the statistics counters

Ports:
clk  input  1  system clock; the single clock for all state
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; low halts sampling
raw_bit  input  1  synchronised TRNG bit (output of the second synchroniser flop)
mode  input  2  0=RAW, 1=VN (von Neumann), 2=XOR2, 3=reserved (treated as RAW)
sample_div  input  DIV_W  sample every sample_div+1 clocks
stat_clr  input  1  synchronous clear of the statistics counters and overflow
out_ready  input  1  consumer accepts word
word_out  output  BITWIDTH  assembled random word
word_valid  output  1  word_out holds an unconsumed word
overflow  output  1  sticky; a completed word was dropped
bit_count  output  CNT_W  number of extracted bits, saturating
ones_count  output  CNT_W  number of extracted 1 bits, saturating

Behaviour:
- Reset (rst_n low, async): all state cleared; word_out=0, word_valid=0, overflow=0, bit_count=0, ones_count=0. Divider, pair phase, shift register and fill count are also 0.
- Divider: counter runs 0..sample_div and then wraps to 0. The strobe fires on the cycle the counter equals sample_div. sample_div=0 gives a strobe every cycle. Counter holds at 0 while ena=0.
- Extraction happens on strobe cycles only:
  - RAW: each sample is emitted as one bit.
  - VN: the first sample of a pair is stored in a and the pair phase is set. On the second sample b: (0,1) emits 0, (1,0) emits 1, equal values emit nothing. The phase is cleared in every case.
  - XOR2: each pair (a,b) emits a^b. Pairs are non-overlapping.
- Assembler:
  - On each emitted bit: shreg <= {shreg[BITWIDTH-2:0], bit} (first bit ends up in the MSB), fill+1.
  - When the BITWIDTH-th bit arrives, the completed word goes to the output register on that same edge if the output register is empty or is being accepted this cycle (word_valid & out_ready). word_valid is high from the next cycle. fill returns to 0.
  - If the output register is full and not being accepted, the word is discarded, overflow is set (sticky) and fill returns to 0.
- Output handshake:
  - Transfer occurs when word_valid & out_ready.
  - word_out must stay stable while word_valid & !out_ready.
  - word_valid drops after a transfer unless a new word loads on the same edge.
- Statistics:
  - On each emitted bit, bit_count increments, and ones_count increments if the bit is 1.
  - Both counters saturate at all-ones.
  - stat_clr clears both counters and overflow; clear wins over an increment in the same cycle.
- ena low: no sampling; pair phase and the partial word (shreg, fill) are cleared. The output register, word_valid, statistics and overflow are held, and the handshake still operates.
- Mode change (mode differs from its registered copy): pair phase and partial word are cleared on that edge and the sample on that cycle is ignored. The output register is unaffected.
- Latency: RAW with sample_div=0 gives word_valid one cycle after the edge that samples the last bit of the word.

Decomposition:
- Package trng_pkg: mode encodings (MODE_RAW, MODE_VN, MODE_XOR2) and the mode type.
- One sub-module, trng_bit_extractor: divider, pair phase, mode logic. Outputs bit_valid/bit_data per cycle.
- The top level holds the assembler, output register, handshake and statistics.

Test Plan:
- Reset mid-word: RAW, div=0, shift 5 bits, assert rst_n=0 -> all outputs 0 immediately; after release, the next word is built from the first 8 post-reset samples.
- RAW, div=0, out_ready=1, raw_bit sequence 1,0,1,1,0,0,1,0 -> word_out=8'hB2, word_valid high for exactly one cycle, bit_count=8, ones_count=4.
- VN, div=0, pairs (0,1),(1,1),(1,0),(0,0) repeated for 8 emitted bits -> word_out=8'h55, bit_count=8, no words emitted from equal pairs (32 samples consumed).
- XOR2, div=3, raw_bit constant 1 -> strobe every 4 clocks; word_out=8'h00 after 64 clocks; ones_count=0.
- Backpressure: RAW, out_ready=0, feed 24 bits -> first word held stable, second word dropped, overflow=1. Raise out_ready for one cycle -> word_valid falls. stat_clr -> overflow=0, counts 0.
- Saturation: CNT_W=4, RAW all ones, 20 samples -> bit_count=ones_count=4'hF and held; mode change mid-word discards the partial word (fill=0).
